// File: rtl/avs_ep_pkg.sv
// AVSBus slave endpoint: shared frame types, codes and CRC-3.
// Imported by the edge synchronizer and the endpoint top.
package avs_ep_pkg;

  localparam int AVS_FRAME_W = 32;

  localparam logic [1:0] CMD_WR_COMMIT = 2'b00;
  localparam logic [1:0] CMD_WR_HOLD   = 2'b01;
  localparam logic [1:0] CMD_RSVD      = 2'b10;
  localparam logic [1:0] CMD_READ      = 2'b11;

  localparam logic [3:0] TYPE_VOUT = 4'h0;
  localparam logic [3:0] TYPE_IOUT = 4'h2;
  localparam logic [3:0] SEL_BCAST = 4'hF;

  typedef struct packed {
    logic [1:0]  start;
    logic [1:0]  cmd;
    logic        grp;
    logic [3:0]  typ;
    logic [3:0]  sel;
    logic [15:0] data;
    logic [2:0]  crc;
  } avs_mframe_t;

  typedef enum logic [1:0] {
    ACK_OK    = 2'b00,
    ACK_NOACT = 2'b01,
    ACK_CRC   = 2'b10,
    ACK_INVAL = 2'b11
  } avs_ack_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX,
    ST_DECODE,
    ST_TX
  } avs_state_e;

  // Serial x^3+x+1 LFSR, MSB first, zero seed.
  function automatic logic [2:0] crc3_f(input logic [28:0] d);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = 28; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

endpackage

// File: rtl/avs_edge_sync.sv
// Two-flop synchronizer with a third flop for edge detection.
// Edges are reported against the synchronized value.
module avs_edge_sync
  import avs_ep_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/avs_slave_ep.sv
// AVSBus slave endpoint emulating a multi-rail VRM.
// Receives master frames, updates rail registers, returns response frames.
module avs_slave_ep
  import avs_ep_pkg::*;
#(
  parameter int          NUM_RAILS = 2,
  parameter logic [15:0] VOUT_RST  = 16'h0320
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   avs_clk_i,
  input  logic                   avs_mdata_i,
  output logic                   avs_sdata_o,
  input  logic [NUM_RAILS*16-1:0] current_i,
  input  logic                   alert_i,
  output logic [NUM_RAILS*16-1:0] vout_o,
  output logic                   vout_upd_o,
  output logic                   crc_err_o,
  output logic                   busy_o
);

  localparam logic [4:0] NR = 5'(NUM_RAILS);

  logic clk_s, clk_rise, clk_fall;
  logic md_s, md_rise, md_fall;
  logic unused_ok;

  avs_edge_sync #(.RST_VAL(1'b0)) u_clk_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (avs_clk_i),
    .q_o    (clk_s),
    .rise_o (clk_rise),
    .fall_o (clk_fall)
  );

  avs_edge_sync #(.RST_VAL(1'b1)) u_md_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (avs_mdata_i),
    .q_o    (md_s),
    .rise_o (md_rise),
    .fall_o (md_fall)
  );

  assign unused_ok = ^{clk_s, md_rise, md_fall};

  avs_state_e state_q, state_d;
  logic [AVS_FRAME_W-1:0] rx_q, rx_d;
  logic [AVS_FRAME_W-1:0] tx_q, tx_d;
  logic [5:0] cnt_q, cnt_d;
  logic zero_q, zero_d;
  logic sdata_q, sdata_d;
  logic upd_q, upd_d;
  logic [NUM_RAILS-1:0][15:0] vout_q, vout_d;
  logic [NUM_RAILS-1:0][15:0] shadow_q, shadow_d;

  avs_mframe_t mf;
  avs_ack_e    ack;
  logic        crc_ok, sel_bc, sel_ok;
  logic        do_wr, do_commit;
  logic [15:0] rdata;
  logic [28:0] resp_body;
  logic [31:0] resp;

  assign mf = rx_q;

  always_comb begin
    crc_ok    = (crc3_f(rx_q[31:3]) == mf.crc);
    sel_bc    = (mf.sel == SEL_BCAST);
    sel_ok    = ({1'b0, mf.sel} < NR);
    ack       = ACK_INVAL;
    rdata     = '0;
    do_wr     = 1'b0;
    do_commit = 1'b0;
    if (!crc_ok) begin
      ack = ACK_CRC;
    end else if (mf.grp) begin
      ack = ACK_NOACT;
    end else begin
      unique case (mf.cmd)
        CMD_WR_COMMIT, CMD_WR_HOLD: begin
          if (mf.typ == TYPE_VOUT && (sel_ok || sel_bc)) begin
            ack       = ACK_OK;
            do_wr     = 1'b1;
            do_commit = (mf.cmd == CMD_WR_COMMIT);
          end
        end
        CMD_READ: begin
          if (sel_ok && (mf.typ == TYPE_VOUT || mf.typ == TYPE_IOUT)) begin
            ack = ACK_OK;
            for (int r = 0; r < NUM_RAILS; r++) begin
              if (mf.sel == 4'(r)) begin
                rdata = (mf.typ == TYPE_VOUT) ? vout_q[r]
                                              : current_i[16*r +: 16];
              end
            end
          end
        end
        default: ack = ACK_INVAL;
      endcase
    end
    resp_body = {ack, 1'b0, alert_i, 4'b0000, rdata, 5'b00000};
    resp      = {resp_body, crc3_f(resp_body)};
  end

  always_comb begin
    state_d  = state_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    sdata_d  = sdata_q;
    shadow_d = shadow_q;
    vout_d   = vout_q;
    upd_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sdata_d = 1'b1;
        if (clk_rise) begin
          rx_d   = {rx_q[30:0], md_s};
          zero_d = ~md_s;
          if (zero_q && md_s) begin
            state_d = ST_RX;
            cnt_d   = 6'd2;
            zero_d  = 1'b0;
          end
        end
      end
      ST_RX: begin
        if (clk_rise) begin
          rx_d  = {rx_q[30:0], md_s};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (do_wr) begin
          for (int r = 0; r < NUM_RAILS; r++) begin
            if (sel_bc || mf.sel == 4'(r)) shadow_d[r] = mf.data;
          end
        end
        if (do_commit) begin
          vout_d = shadow_d;
          upd_d  = (shadow_d != vout_q);
        end
        tx_d    = resp;
        cnt_d   = 6'd0;
        state_d = ST_TX;
      end
      ST_TX: begin
        // Hold the last bit for a full AVS period before releasing.
        if (clk_fall) begin
          if (cnt_q == 6'd32) begin
            sdata_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            sdata_d = tx_q[31];
            tx_d    = {tx_q[30:0], 1'b0};
            cnt_d   = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable_i) begin
      state_d  = ST_IDLE;
      sdata_d  = 1'b1;
      zero_d   = 1'b0;
      shadow_d = shadow_q;
      vout_d   = vout_q;
      upd_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rx_q     <= '0;
      tx_q     <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      sdata_q  <= 1'b1;
      upd_q    <= 1'b0;
      vout_q   <= {NUM_RAILS{VOUT_RST}};
      shadow_q <= {NUM_RAILS{VOUT_RST}};
    end else begin
      state_q  <= state_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      sdata_q  <= sdata_d;
      upd_q    <= upd_d;
      vout_q   <= vout_d;
      shadow_q <= shadow_d;
    end
  end

  assign avs_sdata_o = sdata_q;
  assign vout_o      = vout_q;
  assign vout_upd_o  = upd_q;
  assign crc_err_o   = enable_i && (state_q == ST_DECODE) && !crc_ok;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_avs_slave_ep.sv
// Directed bench for avs_slave_ep with a response scoreboard
// and a behavioural rail-register model.
module tb_avs_slave_ep;

  localparam int          NR = 2;
  localparam logic [15:0] VR = 16'h0320;
  localparam int          H  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic aclk = 1'b1;
  logic mdata = 1'b1;
  logic alert = 1'b0;
  logic [NR*16-1:0] cur = '0;
  logic sdata, upd, cerr, busy;
  logic [NR*16-1:0] vout;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int cerr_cnt = 0;
  logic [31:0] exp_q[$];
  logic [15:0] vm[NR];
  logic [15:0] sm[NR];

  avs_slave_ep #(.NUM_RAILS(NR), .VOUT_RST(VR)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (en),
    .avs_clk_i   (aclk),
    .avs_mdata_i (mdata),
    .avs_sdata_o (sdata),
    .current_i   (cur),
    .alert_i     (alert),
    .vout_o      (vout),
    .vout_upd_o  (upd),
    .crc_err_o   (cerr),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (upd) upd_cnt <= upd_cnt + 1;
    if (cerr) cerr_cnt <= cerr_cnt + 1;
  end

  // Long division of d*x^3 by 1011.
  function automatic logic [2:0] crc_m(input logic [28:0] d);
    logic [31:0] m;
    m = {d, 3'b000};
    for (int i = 31; i >= 3; i--) begin
      if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
    end
    return m[2:0];
  endfunction

  function automatic logic [31:0] mk_resp(input logic [1:0] a,
                                          input logic al,
                                          input logic [15:0] d);
    logic [28:0] b;
    b = {a, 1'b0, al, 4'b0000, d, 5'b00000};
    return {b, crc_m(b)};
  endfunction

  function automatic logic [31:0] vm_flat();
    logic [31:0] v;
    for (int r = 0; r < NR; r++) v[16*r +: 16] = vm[r];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      aclk  = 1'b0;
      mdata = f[31-i];
      half();
      aclk = 1'b1;
      half();
    end
    mdata = 1'b1;
  endtask

  task automatic collect(output logic [31:0] r);
    for (int i = 0; i < 32; i++) begin
      aclk = 1'b0;
      half();
      r[31-i] = sdata;
      aclk = 1'b1;
      half();
    end
    aclk = 1'b0;
    half();
    aclk = 1'b1;
    half();
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      vm[r] = VR;
      sm[r] = VR;
    end
  endtask

  task automatic xact(input string tag, input logic [1:0] cmd,
                      input logic grp, input logic [3:0] typ,
                      input logic [3:0] sel, input logic [15:0] data,
                      input logic flip);
    logic [28:0] body;
    logic [2:0]  c;
    logic [1:0]  a;
    logic [15:0] rd;
    logic        sel_in, ch;
    int          upd_exp, u0, c0;
    logic [31:0] r, e;
    body    = {2'b01, cmd, grp, typ, sel, data};
    c       = crc_m(body);
    if (flip) c[0] = ~c[0];
    a       = 2'b11;
    rd      = 16'h0000;
    upd_exp = 0;
    sel_in  = (sel < 4'(NR));
    if (flip) a = 2'b10;
    else if (grp) a = 2'b01;
    else if (cmd == 2'b00 || cmd == 2'b01) begin
      if (typ == 4'h0 && (sel_in || sel == 4'hF)) begin
        a = 2'b00;
        for (int k = 0; k < NR; k++)
          if (sel == 4'hF || sel == 4'(k)) sm[k] = data;
        if (cmd == 2'b00) begin
          ch = 1'b0;
          for (int k = 0; k < NR; k++) begin
            if (vm[k] != sm[k]) ch = 1'b1;
            vm[k] = sm[k];
          end
          upd_exp = ch ? 1 : 0;
        end
      end
    end else if (cmd == 2'b11) begin
      if (sel_in && typ == 4'h0) begin
        a  = 2'b00;
        rd = vm[sel];
      end else if (sel_in && typ == 4'h2) begin
        a  = 2'b00;
        rd = cur[16*sel +: 16];
      end
    end
    exp_q.push_back(mk_resp(a, alert, rd));
    u0 = upd_cnt;
    c0 = cerr_cnt;
    send_bits({body, c}, 32);
    collect(r);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk({tag, " resp"}, r, e);
    chk({tag, " rcrc"}, {29'b0, r[2:0]}, {29'b0, crc_m(r[31:3])});
    chk({tag, " vout"}, vout, vm_flat());
    chk({tag, " upd"}, upd_cnt - u0, upd_exp);
    chk({tag, " crcerr"}, cerr_cnt - c0, flip ? 1 : 0);
    chk({tag, " busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst sdata", {31'b0, sdata}, 32'd1);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst vout", vout, vm_flat());
    chk("rst upd", upd_cnt, 0);
    chk("rst crcerr", cerr_cnt, 0);

    xact("commit0", 2'b00, 1'b0, 4'h0, 4'h0, 16'h0384, 1'b0);
    xact("hold1", 2'b01, 1'b0, 4'h0, 4'h1, 16'h02EE, 1'b0);
    xact("read1", 2'b11, 1'b0, 4'h0, 4'h1, 16'h0000, 1'b0);
    xact("commit1", 2'b00, 1'b0, 4'h0, 4'h0, 16'h0384, 1'b0);

    cur   = {16'h1234, 16'h0BAD};
    alert = 1'b1;
    xact("curr1", 2'b11, 1'b0, 4'h2, 4'h1, 16'h0000, 1'b0);
    alert = 1'b0;

    xact("badcrc", 2'b00, 1'b0, 4'h0, 4'h0, 16'h0400, 1'b1);
    xact("selnr", 2'b00, 1'b0, 4'h0, 4'(NR), 16'h0111, 1'b0);
    xact("wrtype2", 2'b00, 1'b0, 4'h2, 4'h0, 16'h0222, 1'b0);
    xact("cmd10", 2'b10, 1'b0, 4'h0, 4'h0, 16'h0333, 1'b0);
    xact("rdbcast", 2'b11, 1'b0, 4'h0, 4'hF, 16'h0000, 1'b0);
    xact("vendor", 2'b00, 1'b1, 4'h0, 4'h0, 16'h0444, 1'b0);
    xact("bcast", 2'b00, 1'b0, 4'h0, 4'hF, 16'h0500, 1'b0);

    // Abort by reset after bit 20 of a commit.
    send_bits({2'b01, 2'b00, 1'b0, 4'h0, 4'h0, 16'h0111, 3'b000}, 21);
    chk("mid busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    chk("rstmid sdata", {31'b0, sdata}, 32'd1);
    chk("rstmid busy", {31'b0, busy}, 32'd0);
    chk("rstmid vout", vout, vm_flat());
    rst = 1'b0;
    repeat (4) @(negedge clk);
    xact("afterrst", 2'b00, 1'b0, 4'h0, 4'h1, 16'h0333, 1'b0);

    // Abort by enable drop mid-frame.
    send_bits({2'b01, 2'b00, 1'b0, 4'h0, 4'h0, 16'h0777, 3'b000}, 12);
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("dis busy", {31'b0, busy}, 32'd0);
    chk("dis sdata", {31'b0, sdata}, 32'd1);
    en = 1'b1;
    repeat (4) @(negedge clk);
    xact("afteren", 2'b11, 1'b0, 4'h0, 4'h1, 16'h0000, 1'b0);

    chk("sb empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
